// File: rtl/bfly_out_wr_arbiter_if.sv
// Handshake bundle between the butterfly serial outputs and the DDR3 write channel.
// master: the arbiter's view (takes both upstream ports, drives the write stream).
// slave: the surrounding logic's view (drives the upstream beats, accepts the write stream).
interface bfly_out_wr_arbiter_if #(
  parameter int DATA_WIDTH = 384
);
  logic                  up_vld_A;
  logic [DATA_WIDTH-1:0] up_dat_A;
  logic                  up_rdy_A;
  logic                  up_vld_B;
  logic [DATA_WIDTH-1:0] up_dat_B;
  logic                  up_rdy_B;
  logic                  dn_vld;
  logic [DATA_WIDTH-1:0] dn_dat;
  logic                  dn_src;
  logic                  dn_rdy;

  modport master (
    input  up_vld_A, up_dat_A, up_vld_B, up_dat_B, dn_rdy,
    output up_rdy_A, up_rdy_B, dn_vld, dn_dat, dn_src
  );

  modport slave (
    output up_vld_A, up_dat_A, up_vld_B, up_dat_B, dn_rdy,
    input  up_rdy_A, up_rdy_B, dn_vld, dn_dat, dn_src
  );
endinterface

// File: rtl/bfly_out_wr_arbiter.sv
// Merges butterfly port A (real) and port B (complex) into one DDR3 write stream, burst-locked round-robin.
// Latency: beat written into an empty FIFO at edge N is on dn_vld at edge N+2; one beat/cycle sustained.
// Backpressure: dn_rdy low holds the output register; full FIFOs drop up_rdy_x, and a beat offered anyway is dropped and flagged.
module bfly_out_wr_arbiter #(
  parameter int DATA_WIDTH = 384,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  bfly_out_wr_arbiter_if.master bus,
  output logic [CNT_WIDTH-1:0] beat_cnt_A,
  output logic [CNT_WIDTH-1:0] beat_cnt_B,
  output logic                 ovf_A,
  output logic                 ovf_B
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  // Index 0 is port A, index 1 is port B throughout.
  logic [1:0]            up_vld;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            empty;
  logic [1:0]            full;
  logic [1:0]            drain;
  logic [1:0]            ovf_set;
  logic [DATA_WIDTH-1:0] up_dat [2];
  logic [DATA_WIDTH-1:0] head   [2];

  state_t                state;
  logic                  ptr;        // port favoured when both FIFOs are waiting
  logic [BW-1:0]         burst_cnt;
  logic                  dn_vld_q;
  logic                  dn_src_q;
  logic [DATA_WIDTH-1:0] dn_dat_q;

  logic ld;
  logic gp;
  logic pop_any;
  logic burst_last;
  logic leave;

  assign up_vld    = {bus.up_vld_B, bus.up_vld_A};
  assign up_dat[0] = bus.up_dat_A;
  assign up_dat[1] = bus.up_dat_B;

  // Ready comes straight from registered occupancy: a full FIFO stays not-ready even while it is popped.
  assign bus.up_rdy_A = ~full[0];
  assign bus.up_rdy_B = ~full[1];
  assign ovf_set      = up_vld & full;

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           occ;

    assign full[p]  = (occ == (AW + 1)'(FIFO_DEPTH));
    assign empty[p] = (occ == '0);
    assign push[p]  = up_vld[p] & ~full[p];
    assign head[p]  = mem[rd_ptr];
    // The pop in flight takes the last entry and nothing refills it this cycle.
    assign drain[p] = pop[p] & ~push[p] & (occ == (AW + 1)'(1));

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
      if (push[p]) mem[wr_ptr] <= up_dat[p];
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push[p]) wr_ptr <= wr_ptr + AW'(1);
        if (pop[p])  rd_ptr <= rd_ptr + AW'(1);
        occ <= occ + (AW + 1)'(push[p]) - (AW + 1)'(pop[p]);
      end
    end
  end

  // The output register can take a new beat when empty or when its current beat leaves.
  assign ld         = ~dn_vld_q | bus.dn_rdy;
  assign gp         = (state == GRANT_B);
  assign pop[0]     = (state == GRANT_A) & ld & ~empty[0];
  assign pop[1]     = (state == GRANT_B) & ld & ~empty[1];
  assign pop_any    = |pop;
  assign burst_last = (burst_cnt == BW'(BURST_LEN - 1));
  assign leave      = pop_any & (burst_last | drain[gp]);

  // Grant FSM and the registered output stage, advanced together so a port switch costs no cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      burst_cnt <= '0;
      dn_vld_q  <= 1'b0;
      dn_dat_q  <= '0;
      dn_src_q  <= 1'b0;
    end else begin
      if (ld) begin
        dn_vld_q <= pop_any;
        if (pop_any) begin
          dn_dat_q <= head[gp];
          dn_src_q <= gp;
        end
      end
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (!empty[0] && !empty[1]) state <= ptr ? GRANT_B : GRANT_A;
          else if (!empty[0])         state <= GRANT_A;
          else if (!empty[1])         state <= GRANT_B;
        end
        default: begin
          if (leave) begin
            burst_cnt <= '0;
            ptr       <= ~gp;
            // Hand over if the other port waits; a lone busy port is re-granted
            // in place (fresh burst) so it keeps one beat per cycle.
            if (!empty[~gp])     state <= gp ? GRANT_A : GRANT_B;
            else if (drain[gp])  state <= IDLE;
          end else if (pop_any) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
      endcase
    end
  end

  assign bus.dn_vld = dn_vld_q;
  assign bus.dn_dat = dn_dat_q;
  assign bus.dn_src = dn_src_q;

  // Enqueue counters and sticky overflow flags; clr takes priority over any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_A <= '0;
      beat_cnt_B <= '0;
      ovf_A      <= 1'b0;
      ovf_B      <= 1'b0;
    end else if (clr) begin
      beat_cnt_A <= '0;
      beat_cnt_B <= '0;
      ovf_A      <= 1'b0;
      ovf_B      <= 1'b0;
    end else begin
      if (push[0]) beat_cnt_A <= beat_cnt_A + CNT_WIDTH'(1);
      if (push[1]) beat_cnt_B <= beat_cnt_B + CNT_WIDTH'(1);
      if (ovf_set[0]) ovf_A <= 1'b1;
      if (ovf_set[1]) ovf_B <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bfly_out_wr_arbiter.sv
// Directed bench for bfly_out_wr_arbiter: two instances (FIFO depth 4 and 16) sharing one clock.
// Inputs are driven 1 time unit after the rising edge; outputs sampled on the falling edge or just after reset changes.
module tb_bfly_out_wr_arbiter;

  localparam int DW = 32;
  localparam int CW = 32;

  logic clk;
  logic rst4_n, rst16_n;
  logic clr4, clr16;
  logic [CW-1:0] cnt4_A, cnt4_B, cnt16_A, cnt16_B;
  logic ovf4_A, ovf4_B, ovf16_A, ovf16_B;

  int total;
  int bad;
  int cyc;

  bfly_out_wr_arbiter_if #(.DATA_WIDTH(DW)) b4  ();
  bfly_out_wr_arbiter_if #(.DATA_WIDTH(DW)) b16 ();

  bfly_out_wr_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .BURST_LEN(4), .CNT_WIDTH(CW)) dut4 (
    .clk(clk), .rst_n(rst4_n), .clr(clr4), .bus(b4),
    .beat_cnt_A(cnt4_A), .beat_cnt_B(cnt4_B), .ovf_A(ovf4_A), .ovf_B(ovf4_B)
  );

  bfly_out_wr_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .BURST_LEN(4), .CNT_WIDTH(CW)) dut16 (
    .clk(clk), .rst_n(rst16_n), .clr(clr16), .bus(b16),
    .beat_cnt_A(cnt16_A), .beat_cnt_B(cnt16_B), .ovf_A(ovf16_A), .ovf_B(ovf16_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Accepted-beat logs, recorded on the falling edge when the beat will be taken at the next rising edge.
  logic [DW-1:0] q4_dat [$];
  logic          q4_src [$];
  logic [DW-1:0] q16_dat [$];
  logic          q16_src [$];
  int            q16_cyc [$];

  always @(negedge clk) begin
    if (b4.dn_vld === 1'b1 && b4.dn_rdy === 1'b1) begin
      q4_dat.push_back(b4.dn_dat);
      q4_src.push_back(b4.dn_src);
    end
    if (b16.dn_vld === 1'b1 && b16.dn_rdy === 1'b1) begin
      q16_dat.push_back(b16.dn_dat);
      q16_src.push_back(b16.dn_src);
      q16_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4_n = 1'b0; rst16_n = 1'b0;
    repeat (2) tick();
    total++; if (b4.up_rdy_A !== 1'b1) begin bad++; $display("FAIL reset_up_rdy_A: got %b want 1", b4.up_rdy_A); end
    total++; if (b4.up_rdy_B !== 1'b1) begin bad++; $display("FAIL reset_up_rdy_B: got %b want 1", b4.up_rdy_B); end
    total++; if (b4.dn_vld !== 1'b0) begin bad++; $display("FAIL reset_dn_vld: got %b want 0", b4.dn_vld); end
    total++; if (b4.dn_dat !== '0) begin bad++; $display("FAIL reset_dn_dat: got %h want 0", b4.dn_dat); end
    total++; if (b4.dn_src !== 1'b0) begin bad++; $display("FAIL reset_dn_src: got %b want 0", b4.dn_src); end
    total++; if (cnt4_A !== '0 || cnt4_B !== '0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt4_A, cnt4_B); end
    total++; if (ovf4_A !== 1'b0 || ovf4_B !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b/%b want 0/0", ovf4_A, ovf4_B); end
    total++; if (b16.dn_vld !== 1'b0 || b16.up_rdy_A !== 1'b1) begin bad++; $display("FAIL reset16: dn_vld=%b up_rdy_A=%b want 0/1", b16.dn_vld, b16.up_rdy_A); end
    rst4_n = 1'b1; rst16_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++; if (b4.dn_vld !== 1'b0 || b4.up_rdy_A !== 1'b1) begin bad++; $display("FAIL post_reset_idle: dn_vld=%b up_rdy_A=%b want 0/1", b4.dn_vld, b4.up_rdy_A); end
    tick();
  endtask

  // Eight A beats back to back; the beat written at the first edge shows on dn_vld two edges later.
  task automatic test_a_only();
    int first;
    first = -1;
    q4_dat.delete(); q4_src.delete();
    for (int i = 0; i < 24; i++) begin
      b4.dn_rdy   = 1'b1;
      b4.up_vld_A = (i < 8);
      b4.up_dat_A = DW'(32'h100 + i);
      @(negedge clk);
      if (b4.dn_vld === 1'b1 && first < 0) first = i;
      tick();
    end
    b4.up_vld_A = 1'b0;
    total++; if (first != 3) begin bad++; $display("FAIL a_only_latency: first dn_vld in cycle %0d want 3", first); end
    total++; if (q4_dat.size() != 8) begin bad++; $display("FAIL a_only_count: got %0d beats want 8", q4_dat.size()); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (k >= q4_dat.size() || q4_dat[k] !== DW'(32'h100 + k) || q4_src[k] !== 1'b0) begin
        bad++; $display("FAIL a_only_beat[%0d]: got %h src %b want %h src 0", k, (k < q4_dat.size()) ? q4_dat[k] : '0, (k < q4_src.size()) ? q4_src[k] : 1'b0, DW'(32'h100 + k));
      end
    end
    total++; if (cnt4_A !== CW'(8)) begin bad++; $display("FAIL a_only_beat_cnt_A: got %0d want 8", cnt4_A); end
    total++; if (ovf4_A !== 1'b0) begin bad++; $display("FAIL a_only_ovf_A: got %b want 0", ovf4_A); end
  endtask

  // A streams 10 beats; B offers 2 while A holds the grant. B gets exactly its 2 beats, A resumes with no gap.
  task automatic test_early_yield();
    logic [DW-1:0] exp_dat [12];
    logic          exp_src [12];
    exp_dat = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h300, 32'h301,
                32'h204, 32'h205, 32'h206, 32'h207, 32'h208, 32'h209};
    exp_src = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    q16_dat.delete(); q16_src.delete(); q16_cyc.delete();
    for (int i = 0; i < 30; i++) begin
      b16.dn_rdy   = 1'b1;
      b16.up_vld_A = (i < 10);
      b16.up_dat_A = DW'(32'h200 + i);
      b16.up_vld_B = (i == 1 || i == 2);
      b16.up_dat_B = DW'(32'h300 + i - 1);
      tick();
    end
    b16.up_vld_A = 1'b0; b16.up_vld_B = 1'b0;
    total++; if (q16_dat.size() != 12) begin bad++; $display("FAIL yield_count: got %0d beats want 12", q16_dat.size()); end
    for (int k = 0; k < 12; k++) begin
      total++;
      if (k >= q16_dat.size() || q16_dat[k] !== exp_dat[k] || q16_src[k] !== exp_src[k]) begin
        bad++; $display("FAIL yield_beat[%0d]: got %h src %b want %h src %b", k, (k < q16_dat.size()) ? q16_dat[k] : '0, (k < q16_src.size()) ? q16_src[k] : 1'b0, exp_dat[k], exp_src[k]);
      end
    end
    total++;
    if (q16_cyc.size() < 7 || q16_cyc[4] != q16_cyc[3] + 1 || q16_cyc[6] != q16_cyc[5] + 1) begin
      bad++; $display("FAIL yield_no_gap: handover cycles not back to back (beats logged %0d)", q16_cyc.size());
    end
    total++; if (ovf16_A !== 1'b0 || ovf16_B !== 1'b0) begin bad++; $display("FAIL yield_ovf: got %b/%b want 0/0", ovf16_A, ovf16_B); end
    total++; if (cnt16_A !== CW'(10) || cnt16_B !== CW'(2)) begin bad++; $display("FAIL yield_cnt: got %0d/%0d want 10/2", cnt16_A, cnt16_B); end
  endtask

  // Both ports valid for 8 cycles from a fresh reset: A0-A3, B0-B3, A4-A7, B4-B7, one beat per cycle.
  task automatic test_interleave();
    int            blk;
    logic [DW-1:0] exp;
    rst16_n = 1'b0;
    tick();
    rst16_n = 1'b1;
    q16_dat.delete(); q16_src.delete(); q16_cyc.delete();
    tick();
    for (int i = 0; i < 30; i++) begin
      b16.dn_rdy   = 1'b1;
      b16.up_vld_A = (i < 8);
      b16.up_dat_A = DW'(32'h700 + i);
      b16.up_vld_B = (i < 8);
      b16.up_dat_B = DW'(32'h800 + i);
      tick();
    end
    b16.up_vld_A = 1'b0; b16.up_vld_B = 1'b0;
    total++; if (q16_dat.size() != 16) begin bad++; $display("FAIL ilv_count: got %0d beats want 16", q16_dat.size()); end
    for (int k = 0; k < 16; k++) begin
      blk = k / 4;
      exp = (blk % 2 == 1) ? DW'(32'h800 + (blk / 2) * 4 + k % 4) : DW'(32'h700 + (blk / 2) * 4 + k % 4);
      total++;
      if (k >= q16_dat.size() || q16_dat[k] !== exp || q16_src[k] !== (blk % 2 == 1)) begin
        bad++; $display("FAIL ilv_beat[%0d]: got %h want %h", k, (k < q16_dat.size()) ? q16_dat[k] : '0, exp);
      end
    end
    total++;
    if (q16_cyc.size() != 16 || q16_cyc[15] != q16_cyc[0] + 15) begin
      bad++; $display("FAIL ilv_throughput: 16 beats not on consecutive cycles (beats logged %0d)", q16_cyc.size());
    end
    total++; if (ovf16_A !== 1'b0 || ovf16_B !== 1'b0) begin bad++; $display("FAIL ilv_ovf: got %b/%b want 0/0", ovf16_A, ovf16_B); end
    total++; if (cnt16_A !== CW'(8) || cnt16_B !== CW'(8)) begin bad++; $display("FAIL ilv_cnt: got %0d/%0d want 8/8", cnt16_A, cnt16_B); end
  endtask

  // dn_rdy low for 10 cycles while A offers 6 beats into a depth-4 FIFO: 5 are held, the 6th overflows.
  task automatic test_backpressure();
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    total++; if (cnt4_A !== '0 || ovf4_A !== 1'b0) begin bad++; $display("FAIL bp_clr: cnt_A=%0d ovf_A=%b want 0/0", cnt4_A, ovf4_A); end
    q4_dat.delete(); q4_src.delete();
    for (int i = 0; i < 10; i++) begin
      b4.dn_rdy   = 1'b0;
      b4.up_vld_A = (i < 6);
      b4.up_dat_A = DW'(32'h400 + i);
      @(negedge clk);
      total++; if (b4.up_rdy_A !== (i < 5)) begin bad++; $display("FAIL bp_up_rdy[%0d]: got %b want %b", i, b4.up_rdy_A, (i < 5)); end
      if (i >= 3) begin
        total++;
        if (b4.dn_vld !== 1'b1 || b4.dn_dat !== DW'(32'h400)) begin bad++; $display("FAIL bp_hold[%0d]: dn_vld=%b dn_dat=%h want 1/%h", i, b4.dn_vld, b4.dn_dat, DW'(32'h400)); end
      end
      total++; if (ovf4_A !== (i >= 6)) begin bad++; $display("FAIL bp_ovf[%0d]: got %b want %b", i, ovf4_A, (i >= 6)); end
      tick();
    end
    b4.up_vld_A = 1'b0;
    b4.dn_rdy   = 1'b1;
    repeat (15) tick();
    total++; if (q4_dat.size() != 5) begin bad++; $display("FAIL bp_count: got %0d beats want 5", q4_dat.size()); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (k >= q4_dat.size() || q4_dat[k] !== DW'(32'h400 + k)) begin
        bad++; $display("FAIL bp_beat[%0d]: got %h want %h", k, (k < q4_dat.size()) ? q4_dat[k] : '0, DW'(32'h400 + k));
      end
    end
    total++; if (cnt4_A !== CW'(5)) begin bad++; $display("FAIL bp_beat_cnt_A: got %0d want 5", cnt4_A); end
    total++; if (b4.up_rdy_A !== 1'b1) begin bad++; $display("FAIL bp_rdy_back: got %b want 1", b4.up_rdy_A); end
  endtask

  // clr in the same cycle as an A enqueue (count 5, ovf set): clr wins, the beat is still delivered.
  task automatic test_clr();
    q4_dat.delete(); q4_src.delete();
    b4.dn_rdy   = 1'b1;
    b4.up_vld_A = 1'b1;
    b4.up_dat_A = DW'(32'h500);
    clr4        = 1'b1;
    tick();
    clr4        = 1'b0;
    b4.up_vld_A = 1'b0;
    total++; if (cnt4_A !== '0) begin bad++; $display("FAIL clr_cnt_A: got %0d want 0", cnt4_A); end
    total++; if (ovf4_A !== 1'b0) begin bad++; $display("FAIL clr_ovf_A: got %b want 0", ovf4_A); end
    repeat (8) tick();
    total++;
    if (q4_dat.size() != 1 || q4_dat[0] !== DW'(32'h500)) begin bad++; $display("FAIL clr_data: got %0d beats first %h want 1 beat 500", q4_dat.size(), (q4_dat.size() > 0) ? q4_dat[0] : '0); end
    total++; if (cnt4_A !== '0) begin bad++; $display("FAIL clr_cnt_hold: got %0d want 0", cnt4_A); end
  endtask

  // Reset mid-cycle with 3 beats buffered: outputs clear at once and nothing stale appears afterwards.
  task automatic test_async_reset();
    b4.dn_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b4.up_vld_A = 1'b1;
      b4.up_dat_A = DW'(32'h600 + i);
      tick();
    end
    b4.up_vld_A = 1'b0;
    repeat (2) tick();
    total++; if (b4.dn_vld !== 1'b1) begin bad++; $display("FAIL ar_pre_vld: got %b want 1", b4.dn_vld); end
    #2;
    rst4_n = 1'b0;
    #1;
    total++; if (b4.dn_vld !== 1'b0) begin bad++; $display("FAIL ar_dn_vld: got %b want 0", b4.dn_vld); end
    total++; if (b4.dn_dat !== '0) begin bad++; $display("FAIL ar_dn_dat: got %h want 0", b4.dn_dat); end
    total++; if (b4.up_rdy_A !== 1'b1 || b4.up_rdy_B !== 1'b1) begin bad++; $display("FAIL ar_up_rdy: got %b/%b want 1/1", b4.up_rdy_A, b4.up_rdy_B); end
    total++; if (cnt4_A !== '0) begin bad++; $display("FAIL ar_cnt_A: got %0d want 0", cnt4_A); end
    @(negedge clk);
    rst4_n = 1'b1;
    q4_dat.delete(); q4_src.delete();
    tick();
    b4.dn_rdy = 1'b1;
    repeat (10) tick();
    total++; if (q4_dat.size() != 0) begin bad++; $display("FAIL ar_stale: got %0d beats want 0", q4_dat.size()); end
    total++; if (b4.dn_vld !== 1'b0) begin bad++; $display("FAIL ar_idle_vld: got %b want 0", b4.dn_vld); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst4_n = 1'b0; rst16_n = 1'b0; clr4 = 1'b0; clr16 = 1'b0;
    b4.up_vld_A = 1'b0; b4.up_dat_A = '0; b4.up_vld_B = 1'b0; b4.up_dat_B = '0; b4.dn_rdy = 1'b0;
    b16.up_vld_A = 1'b0; b16.up_dat_A = '0; b16.up_vld_B = 1'b0; b16.up_dat_B = '0; b16.dn_rdy = 1'b0;
    tick();
    test_reset();
    test_a_only();
    test_early_yield();
    test_interleave();
    test_backpressure();
    test_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bfly_out_wr_arbiter.md
Name: bfly_out_wr_arbiter

Overview:
- Sits between the butterfly processor serial outputs (port A real, port B complex) and the DDR3 output write channel.
- Replaces the direct A-over-B output mux, which silently loses a B beat whenever both ports are valid in the same cycle.
- Buffers each port in a small FIFO and grants the single write stream with burst-locked round-robin.
- Counts accepted beats and flags any beat offered while its FIFO is full.

Parameters:
- DATA_WIDTH, 384, width of one output beat (data_width*be_parallelism).
- FIFO_DEPTH, 4, entries per port FIFO; power of two, minimum 2.
- BURST_LEN, 4, maximum consecutive grants to one port before yielding; minimum 1.
- CNT_WIDTH, 32, width of the beat counters.

Ports:
- clk  input  1  clock, same domain as sys_clk.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of counters and overflow flags.
- up_vld_A  input  1  port A beat valid.
- up_dat_A  input  DATA_WIDTH  port A beat.
- up_rdy_A  output  1  port A FIFO not full.
- up_vld_B  input  1  port B beat valid.
- up_dat_B  input  DATA_WIDTH  port B beat.
- up_rdy_B  output  1  port B FIFO not full.
- dn_vld  output  1  write beat valid; drives start_write_output.
- dn_dat  output  DATA_WIDTH  write beat.
- dn_src  output  1  source of the current beat: 0=A, 1=B.
- dn_rdy  input  1  downstream accepts the beat.
- beat_cnt_A  output  CNT_WIDTH  beats accepted from A.
- beat_cnt_B  output  CNT_WIDTH  beats accepted from B.
- ovf_A  output  1  sticky: beat offered on A while its FIFO was full.
- ovf_B  output  1  sticky: beat offered on B while its FIFO was full.

Behaviour:
- Reset values: all FIFOs empty; up_rdy_A/B=1; dn_vld=0; dn_dat=0; dn_src=0; counters=0; ovf_A/B=0; grant pointer=A; burst counter=0.
- Enqueue: a beat is written to a port FIFO when up_vld_x && up_rdy_x.
- up_rdy_x = !full_x, taken from registered occupancy. There is no combinational bypass: a full FIFO deasserts rdy even in a cycle in which it is also being popped.
- Overflow: up_vld_x && !up_rdy_x sets ovf_x and drops the beat. Upstream ties its rdy high, so a drop is an error condition.
- Output register: dn_vld/dn_dat/dn_src form one registered stage.
  - The stage loads when it is empty or (dn_vld && dn_rdy).
  - dn_dat and dn_src hold while dn_vld && !dn_rdy.
- Latency: a beat written into an empty FIFO at edge N, with the output stage free, appears on dn_vld at edge N+2.
- Throughput: one beat per cycle sustained while dn_rdy=1.
- Arbitration FSM, states IDLE, GRANT_A, GRANT_B:
  - IDLE: if both FIFOs are non-empty, go to the port the pointer names. If only one is non-empty, go to that port. Burst counter is cleared.
  - GRANT_x: pop one beat of x per output-stage load and increment the burst counter.
  - Leave GRANT_x when the burst counter reaches BURST_LEN, or when FIFO x becomes empty, whichever comes first.
  - On leaving: go to the other port if it is non-empty, else IDLE. The pointer is set to the other port.
  - A port with a non-empty FIFO therefore waits at most BURST_LEN beats.
- Counters: beat_cnt_x increments on each enqueue and wraps modulo 2^CNT_WIDTH.
- clr: zeroes counters and ovf flags only; FIFO contents and the FSM are untouched. If clr and an increment occur in the same cycle, clr wins.
- Simultaneous push and pop on the same FIFO: occupancy unchanged; both pointers advance.
- Asynchronous reset during operation: all buffered beats are discarded and every output returns to its reset value immediately.

Test Plan:
- A only: 8 beats A0..A7 back-to-back, dn_rdy=1 -> dn emits A0..A7 in order, dn_src=0, first dn_vld 2 cycles after the first up_vld; beat_cnt_A=8.
- A and B both valid for 8 cycles, BURST_LEN=4, FIFO_DEPTH=16 -> output order A0-A3, B0-B3, A4-A7, B4-B7; no ovf.
- Backpressure: dn_rdy=0 for 10 cycles while A streams 6 beats, FIFO_DEPTH=4 -> up_rdy_A falls after 4 buffered beats plus 1 in the output stage; beat 6 sets ovf_A=1; dn_dat stable throughout; 5 beats emitted once dn_rdy=1.
- Early yield: B sends 2 beats while A streams continuously -> B's burst ends after 2 beats and A is granted immediately with no idle cycle.
- clr in the same cycle as an A enqueue, with beat_cnt_A=5 and ovf_A=1 -> beat_cnt_A=0, ovf_A=0; FIFO data is still delivered.
- rst_n pulsed low with 3 beats buffered -> dn_vld=0 asynchronously; after release no stale beats are emitted; up_rdy_A/B=1.
